if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Holds the PC and a direct-mapped, one-word-per-line instruction cache.
- Runs a miss/refill FSM against a word-wide memory port with a req/ack handshake.
- Drives `instruction`, `nextPC` (PC+4) and `hit` to IF/ID; IF/ID captures only when `hit`=1.

---
 rtl/if_fetch_stage.sv | 135 +++++++++++++
 tb/tb_if_fetch_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line I-cache and miss/refill FSM.
// Optional hit/miss counters are enabled with `define IF_FETCH_PERF_COUNTERS_EN.
module if_fetch_stage #(
    parameter int unsigned     SIZE       = 32,
    parameter int unsigned     INDEX_BITS = 4,
    parameter logic [SIZE-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branchTaken,
    input  logic [SIZE-1:0] branchTarget,
    input  logic            memAck,
    input  logic [SIZE-1:0] memData,
    output logic            memReq,
    output logic [SIZE-1:0] memAddr,
    output logic [SIZE-1:0] pc,
    output logic [SIZE-1:0] instruction,
    output logic [SIZE-1:0] nextPC,
    output logic            hit
`ifdef IF_FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]     hitCount,
    output logic [31:0]     missCount
`endif
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = SIZE - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

    state_t                state;
    logic [SIZE-1:0]       data_arr [LINES];
    logic [TAG_BITS-1:0]   tag_arr  [LINES];
    logic [LINES-1:0]      valid;
    logic                  pend;
    logic [SIZE-1:0]       pend_target;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [SIZE-1:0]       target_al;
    logic                  fill_en;

    assign idx         = pc[INDEX_BITS+1:2];
    assign tag         = pc[SIZE-1:INDEX_BITS+2];
    assign target_al   = branchTarget & ~SIZE'(3);
    assign hit         = (state == IDLE) && valid[idx] && (tag_arr[idx] == tag);
    assign instruction = data_arr[idx];
    assign nextPC      = pc + SIZE'(4);
    assign fill_en     = (state == REQ) && memAck;

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_arr[idx] <= memData;
            tag_arr[idx]  <= tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            valid       <= '0;
            memReq      <= 1'b0;
            memAddr     <= '0;
            pend        <= 1'b0;
            pend_target <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (branchTaken) begin
                            pc <= target_al;
                        end else if (!stall) begin
                            pc <= nextPC;
                        end
                    end else begin
                        state   <= REQ;
                        memReq  <= 1'b1;
                        memAddr <= {pc[SIZE-1:2], 2'b00};
                        if (branchTaken) begin
                            pend        <= 1'b1;
                            pend_target <= target_al;
                        end
                    end
                end
                REQ: begin
                    // Redirects are parked until the refill has landed; the bus is never aborted.
                    if (branchTaken) begin
                        pend        <= 1'b1;
                        pend_target <= target_al;
                    end
                    if (memAck) begin
                        valid[idx] <= 1'b1;
                        memReq     <= 1'b0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (branchTaken) begin
                        pc <= target_al;
                    end else if (pend) begin
                        pc <= pend_target;
                    end
                    pend  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            if (hit && !stall && (hitCount != '1)) begin
                hitCount <= hitCount + 32'd1;
            end
            if ((state == IDLE) && !hit && (missCount != '1)) begin
                missCount <= missCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected captures and refill addresses are queued by the
// stimulus and consumed by an IF/ID-capture monitor and a memory responder.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b1;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        memAck;
    logic [31:0] memData;
    logic        memReq;
    logic [31:0] memAddr;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] nextPC;
    logic        hit;
`ifdef IF_FETCH_PERF_COUNTERS_EN
    logic [31:0] hitCount;
    logic [31:0] missCount;
    logic [31:0] miss_snap;
`endif

    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] resp_data = '0;
    logic [31:0] spur_data = '0;
    assign memAck  = resp_ack | spur_ack;
    assign memData = spur_ack ? spur_data : resp_data;

    if_fetch_stage #(
        .SIZE(32),
        .INDEX_BITS(4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branchTaken(branchTaken),
        .branchTarget(branchTarget),
        .memAck(memAck),
        .memData(memData),
        .memReq(memReq),
        .memAddr(memAddr),
        .pc(pc),
        .instruction(instruction),
        .nextPC(nextPC),
        .hit(hit)
`ifdef IF_FETCH_PERF_COUNTERS_EN
        ,
        .hitCount(hitCount),
        .missCount(missCount)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned ack_cyc = 0;
    int unsigned ack_count = 0;
    int unsigned ack_delay = 3;
    int unsigned req_cnt = 0;
    int unsigned captures = 0;
    logic [31:0] req_addr = '0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        hq[$];
    logic [31:0] mq[$];

    logic [31:0] warm_instr [8] = '{32'h2008_0005, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C,
                                    32'h1000_0010, 32'h1000_0014, 32'h1000_0018, 32'h1000_001C};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : (32'h1000_0000 | a);
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: checks refill address against the queue, acks on the ack_delay-th cycle of memReq.
    always @(negedge clk) begin
        if (!rst_n || !memReq) begin
            req_cnt  = 0;
            resp_ack = 1'b0;
        end else begin
            req_cnt++;
            if (req_cnt == 1) begin
                req_addr = memAddr;
                if (mq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_miss actual=%h expected=none", memAddr);
                end else begin
                    chk("miss_addr", memAddr, mq.pop_front());
                end
            end else begin
                chk("addr_stable", memAddr, req_addr);
            end
            resp_ack = (req_cnt == ack_delay);
            if (resp_ack) begin
                resp_data = memword(memAddr);
                ack_cyc   = cyc;
                ack_count++;
            end
        end
    end

    // IF/ID capture monitor.
    always @(negedge clk) begin
        if (rst_n && hit && !stall) begin
            if (hq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_hit actual=%h expected=none", pc);
            end else begin
                exp_t e;
                e = hq.pop_front();
                chk("cap_pc", pc, e.pc);
                chk("cap_instr", instruction, e.instr);
                chk("cap_nextpc", nextPC, e.pc + 32'd4);
                captures++;
            end
        end
    end

    task automatic wait_hit(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hit && n < 200);
        chk(name, {31'd0, hit}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!memReq && n < 50);
        chk(name, {31'd0, memReq}, 32'd1);
    endtask

    task automatic capture(input logic [31:0] p, input logic [31:0] ins, input logic br,
                           input logic [31:0] tgt);
        hq.push_back('{p, ins});
        @(posedge clk); #1;
        stall = 1'b0;
        branchTaken = br;
        branchTarget = tgt;
        @(posedge clk); #1;
        stall = 1'b1;
        branchTaken = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int unsigned ac0;
        int unsigned n;
        // Reset state
        #22;
        chk("rst_pc", pc, 32'h0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_memreq", {31'd0, memReq}, 32'd0);
        chk("rst_memaddr", memAddr, 32'h0);
`ifdef IF_FETCH_PERF_COUNTERS_EN
        chk("rst_hitcount", hitCount, 32'h0);
        chk("rst_misscount", missCount, 32'h0);
`endif
        mq.push_back(32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cold start
        wait_hit("cold_hit");
        chk("cold_latency", cyc, ack_cyc + 32'd2);
        capture(32'h0, 32'h2008_0005, 1'b0, 32'h0);

        // Refill 0x04..0x1C, redirect to 0x3 on the last capture
        for (int unsigned i = 1; i < 8; i++) begin
            ack_delay = (i % 2 == 1) ? 1 : 2;
            mq.push_back(i * 4);
            wait_hit("fill_hit");
            capture(i * 4, warm_instr[i], (i == 7), 32'h0000_0003);
        end
        chk("mask_pc", pc, 32'h0);
        chk("mask_hit", {31'd0, hit}, 32'd1);

        // Warm loop: 8 consecutive hits, no memory traffic
        for (int unsigned i = 0; i < 8; i++) hq.push_back('{i * 4, warm_instr[i]});
        @(posedge clk); #1;
        stall = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i == 7) begin
                branchTaken = 1'b1;
                branchTarget = 32'h0;
            end
            @(posedge clk); #1;
            chk("warm_memreq", {31'd0, memReq}, 32'd0);
        end
        branchTaken = 1'b0;
        stall = 1'b1;
        chk("warm_pc", pc, 32'h0);

        // Stall holds pc with hit asserted
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_pc", pc, 32'h0);
            chk("stall_hit", {31'd0, hit}, 32'd1);
        end

        // memAck outside REQ is ignored
        spur_data = 32'hDEAD_BEEF;
        spur_ack = 1'b1;
        @(posedge clk); #1;
        spur_ack = 1'b0;
        @(posedge clk); #1;
        chk("spur_hit", {31'd0, hit}, 32'd1);
        chk("spur_instr", instruction, 32'h2008_0005);
        chk("spur_pc", pc, 32'h0);

        // Branch beats stall
        branchTaken = 1'b1;
        branchTarget = 32'h80;
        @(posedge clk); #1;
        branchTaken = 1'b0;
        chk("brstall_pc", pc, 32'h80);
        chk("brstall_hit", {31'd0, hit}, 32'd0);
        ack_delay = 2;
        mq.push_back(32'h80);
        wait_hit("h80_hit");

        // Conflict on index 0
`ifdef IF_FETCH_PERF_COUNTERS_EN
        miss_snap = missCount;
`endif
        capture(32'h80, 32'h1000_0080, 1'b1, 32'h0);
        mq.push_back(32'h0);
        wait_hit("conf0_hit");
        capture(32'h0, 32'h2008_0005, 1'b1, 32'h40);
        mq.push_back(32'h40);
        wait_hit("conf40_hit");
        capture(32'h40, 32'h1000_0040, 1'b1, 32'h0);
        mq.push_back(32'h0);
        wait_hit("conf0b_hit");
`ifdef IF_FETCH_PERF_COUNTERS_EN
        chk("conf_misscount", missCount - miss_snap, 32'd3);
`endif

        // Redirect mid-miss, second redirect overwrites the first
        capture(32'h0, 32'h2008_0005, 1'b1, 32'h44);
        ack_delay = 5;
        mq.push_back(32'h44);
        mq.push_back(32'h100);
        ac0 = ack_count;
        wait_req("mid_req");
        @(posedge clk); #1;
        branchTaken = 1'b1;
        branchTarget = 32'h200;
        @(posedge clk); #1;
        branchTarget = 32'h101;
        @(posedge clk); #1;
        branchTaken = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack_count != ac0 && cyc == ack_cyc + 2) && n < 50);
        chk("mid_pc", pc, 32'h100);
        chk("mid_hit", {31'd0, hit}, 32'd0);
        ack_delay = 2;
        wait_hit("h100_hit");
        capture(32'h100, 32'h1000_0100, 1'b1, 32'h44);
        chk("old_line_hit", {31'd0, hit}, 32'd1);

        // Wrap of nextPC at the top of the address space
        capture(32'h44, 32'h1000_0044, 1'b1, 32'hFFFF_FFFC);
        mq.push_back(32'hFFFF_FFFC);
        wait_hit("top_hit");
        capture(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        mq.push_back(32'h0);
        wait_hit("wrap0_hit");

        // Async reset during REQ
        capture(32'h0, 32'h2008_0005, 1'b0, 32'h0);
        ack_delay = 50;
        mq.push_back(32'h4);
        wait_req("ar_req");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("ar_memreq", {31'd0, memReq}, 32'd0);
        chk("ar_pc", pc, 32'h0);
        captures = 0;
        ack_delay = 2;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ar_rel_pc", pc, 32'h0);
        chk("ar_rel_hit", {31'd0, hit}, 32'd0);
        mq.push_back(32'h0);
        wait_hit("ar_hit");
        capture(32'h0, 32'h2008_0005, 1'b0, 32'h0);
        mq.push_back(32'h4);
        wait_hit("ar4_hit");
`ifdef IF_FETCH_PERF_COUNTERS_EN
        chk("ar_hitcount", hitCount, captures);
        chk("ar_misscount", missCount, 32'd2);
`endif

        chk("hq_drained", hq.size(), 32'd0);
        chk("mq_drained", mq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
